// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifu_fetch : PC owner, req/gnt/rvalid word fetch, 2-entry fetch queue |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module ifu_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        busy_o
);

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  discard_q, discard_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] tag_q      [2];
  logic [31:0] tag_d      [2];
  logic [31:0] q_inst_q   [2];
  logic [31:0] q_inst_d   [2];
  logic [31:0] q_addr_q   [2];
  logic [31:0] q_addr_d   [2];

  logic        pop;
  logic        push;
  logic        xfer;
  logic [2:0]  credit_used;
  logic [1:0]  tag_fill;
  logic [1:0]  q_fill;

  always_comb begin
    pop         = !hold_flag_i && (count_q != 2'd0) && !jump_flag_i;
    credit_used = {1'b0, outst_q} + {1'b0, count_q} - {2'b00, pop};
    ibus_req_o  = !rst && !jump_flag_i && (credit_used < 3'd2);
    ibus_addr_o = pc_q;
    xfer        = ibus_req_o && ibus_gnt_i;
    push        = ibus_rvalid_i && (discard_q == 2'd0) && !jump_flag_i;
    tag_fill    = outst_q - {1'b0, ibus_rvalid_i};
    q_fill      = count_q - {1'b0, pop};
  end

  always_comb begin
    pc_d      = pc_q;
    outst_d   = outst_q + {1'b0, xfer} - {1'b0, ibus_rvalid_i};
    discard_d = discard_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    tag_d     = tag_q;
    q_inst_d  = q_inst_q;
    q_addr_d  = q_addr_q;

    // Tag FIFO mirrors the in-flight requests; slot 0 is the oldest.
    if (ibus_rvalid_i) begin
      tag_d[0] = tag_q[1];
    end
    if (xfer) begin
      tag_d[tag_fill[0]] = pc_q;
      pc_d               = pc_q + 32'd4;
    end

    if (ibus_rvalid_i && (discard_q != 2'd0)) begin
      discard_d = discard_q - 2'd1;
    end

    if (pop) begin
      q_inst_d[0] = q_inst_q[1];
      q_addr_d[0] = q_addr_q[1];
    end
    if (push) begin
      q_inst_d[q_fill[0]] = ibus_rdata_i;
      q_addr_d[q_fill[0]] = tag_q[0];
    end

    // A redirect kills the queue; responses still owed get squashed later.
    if (jump_flag_i) begin
      pc_d      = jump_addr_i & WORD_MASK;
      count_d   = 2'd0;
      discard_d = outst_q - {1'b0, ibus_rvalid_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_ADDR & WORD_MASK;
      outst_q   <= 2'd0;
      discard_q <= 2'd0;
      count_q   <= 2'd0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
    end
    tag_q    <= tag_d;
    q_inst_q <= q_inst_d;
    q_addr_q <= q_addr_d;
  end

  always_comb begin
    inst_o      = INST_NOP;
    inst_addr_o = 32'd0;
    if (!rst && (count_q != 2'd0)) begin
      inst_o      = q_inst_q[0];
      inst_addr_o = q_addr_q[0];
    end
    busy_o = !rst && (count_q == 2'd0);
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifu_fetch : directed vectors + bus model + scoreboard for ifu     |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_ifu_fetch;

  localparam logic [31:0] RST_ADDR = 32'h0000_0102;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold_flag_i = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'd0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        busy_o;

  ifu_fetch #(.RESET_ADDR(RST_ADDR)) dut (
    .clk(clk), .rst(rst),
    .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus model ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pq[$];
  bit bus_auto  = 1'b0;
  int stall_max = 0;
  int lat_min   = 1;
  int lat_max   = 1;
  int cyc       = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_auto) begin
        ibus_gnt_i = ($urandom_range(0, stall_max) == 0);
        if (pq.size() > 0 && pq[0].due <= cyc) begin
          ibus_rvalid_i = 1'b1;
          ibus_rdata_i  = pq[0].addr ^ KEY;
        end else begin
          ibus_rvalid_i = 1'b0;
          ibus_rdata_i  = 32'hDEAD_BEEF;
        end
      end
      #3;
      if (bus_auto) begin
        if (rst) pq.delete();
        else begin
          if (ibus_rvalid_i) void'(pq.pop_front());
          if (ibus_req_o && ibus_gnt_i)
            pq.push_back('{ibus_addr_o, cyc + int'($urandom_range(lat_min, lat_max))});
        end
      end
    end
  end

  // ---------------- scoreboard / invariant monitor ----------------
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] fd_addr = 32'd0;
  bit          fd_valid = 1'b0;
  int          deliveries = 0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        exp_pc   = RST_ADDR & 32'hFFFF_FFFC;
        fd_valid = 1'b0;
      end else begin
        chk("credit_inv", {31'd0, (int'(dut.outst_q) + int'(dut.count_q)) <= 2}, 32'd1);
        if (ibus_rvalid_i) chk("rvalid_outst", {31'd0, dut.outst_q != 2'd0}, 32'd1);
        if (jump_flag_i) begin
          exp_pc   = jump_addr_i & 32'hFFFF_FFFC;
          fd_valid = 1'b0;
        end else if (!hold_flag_i && !busy_o) begin
          deliveries++;
          chk("seq_addr", inst_addr_o, exp_pc);
          chk("seq_data", inst_o, inst_addr_o ^ KEY);
          if (!fd_valid) begin
            fd_valid = 1'b1;
            fd_addr  = inst_addr_o;
          end
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        hold, jump;
    logic [31:0] jaddr;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, inst, iaddr;
    logic        busy;
  } vec_t;
  vec_t vecs[12];

  function automatic vec_t mk(logic h, logic j, logic [31:0] ja, logic g, logic r,
                              logic [31:0] rd, logic rq, logic [31:0] ad,
                              logic [31:0] in, logic [31:0] ia, logic b);
    vec_t v;
    v.hold = h; v.jump = j; v.jaddr = ja; v.gnt = g; v.rv = r; v.rdata = rd;
    v.req = rq; v.addr = ad; v.inst = in; v.iaddr = ia; v.busy = b;
    return v;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; hold_flag_i = 1'b0; jump_flag_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_req", {31'd0, ibus_req_o}, 32'd0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_iaddr", inst_addr_o, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] frozen;
    int r;

    vecs[0]  = mk(0,0,0,        1,0,0,                    1,32'h100, NOP,               32'h0,    1);
    vecs[1]  = mk(0,0,0,        1,1,32'h100^KEY,          1,32'h104, NOP,               32'h0,    1);
    vecs[2]  = mk(1,0,0,        0,0,0,                    0,32'h108, 32'h100^KEY,       32'h100,  0);
    vecs[3]  = mk(1,0,0,        1,1,32'h104^KEY,          0,32'h108, 32'h100^KEY,       32'h100,  0);
    vecs[4]  = mk(1,0,0,        1,0,0,                    0,32'h108, 32'h100^KEY,       32'h100,  0);
    vecs[5]  = mk(0,0,0,        1,0,0,                    1,32'h108, 32'h100^KEY,       32'h100,  0);
    vecs[6]  = mk(0,0,0,        0,0,0,                    1,32'h10C, 32'h104^KEY,       32'h104,  0);
    vecs[7]  = mk(0,1,32'h2003, 1,0,0,                    0,32'h10C, NOP,               32'h0,    1);
    vecs[8]  = mk(0,0,0,        1,1,32'h108^KEY,          1,32'h2000,NOP,               32'h0,    1);
    vecs[9]  = mk(0,0,0,        0,1,32'h2000^KEY,         1,32'h2004,NOP,               32'h0,    1);
    vecs[10] = mk(0,0,0,        0,0,0,                    1,32'h2004,32'h2000^KEY,      32'h2000, 0);
    vecs[11] = mk(0,0,0,        0,0,0,                    1,32'h2004,NOP,               32'h0,    1);

    // Reset with bus pulling gnt, then hand-driven bus vectors.
    bus_auto = 1'b0; ibus_gnt_i = 1'b1; ibus_rvalid_i = 1'b0;
    do_reset(3);
    for (int i = 0; i < 12; i++) begin
      hold_flag_i = vecs[i].hold; jump_flag_i = vecs[i].jump; jump_addr_i = vecs[i].jaddr;
      ibus_gnt_i = vecs[i].gnt; ibus_rvalid_i = vecs[i].rv; ibus_rdata_i = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i),   {31'd0, ibus_req_o}, {31'd0, vecs[i].req});
      chk($sformatf("v%0d_addr", i),  ibus_addr_o, vecs[i].addr);
      chk($sformatf("v%0d_inst", i),  inst_o, vecs[i].inst);
      chk($sformatf("v%0d_iaddr", i), inst_addr_o, vecs[i].iaddr);
      chk($sformatf("v%0d_busy", i),  {31'd0, busy_o}, {31'd0, vecs[i].busy});
      @(negedge clk);
    end
    hold_flag_i = 1'b0; jump_flag_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;

    // Streaming, zero-wait grant, 1-cycle response.
    bus_auto = 1'b1; stall_max = 0; lat_min = 1; lat_max = 1;
    do_reset(2);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("stream_busy", {31'd0, busy_o}, 32'd0);
      chk("stream_addr", inst_addr_o, 32'h100 + 32'(4 * c));
      @(negedge clk);
    end

    // Hold for 5 cycles mid-stream.
    hold_flag_i = 1'b1;
    #1;
    frozen = inst_o;
    chk("hold_head", inst_addr_o, 32'h150);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) #1;
      chk("hold_inst", inst_o, frozen);
      chk("hold_req", {31'd0, ibus_req_o}, 32'd0);
      @(negedge clk);
    end
    hold_flag_i = 1'b0;
    #1;
    chk("resume_req", {31'd0, ibus_req_o}, 32'd1);
    chk("resume_a0", inst_addr_o, 32'h150);
    @(negedge clk); #1;
    chk("resume_a1", inst_addr_o, 32'h154);
    @(negedge clk); #1;
    chk("resume_a2", inst_addr_o, 32'h158);
    @(negedge clk);

    // Jump while two requests are in flight (3-cycle response).
    lat_min = 3; lat_max = 3;
    do_reset(2);
    repeat (2) @(negedge clk);
    jump_flag_i = 1'b1; jump_addr_i = 32'h2000;
    #1;
    chk("j2_req", {31'd0, ibus_req_o}, 32'd0);
    @(negedge clk);
    jump_flag_i = 1'b0;
    #1;
    chk("j2_nop", inst_o, NOP);
    chk("j2_addr", ibus_addr_o, 32'h2000);
    chk("j2_req_full", {31'd0, ibus_req_o}, 32'd0);
    repeat (15) @(negedge clk);
    chk("j2_fd_valid", {31'd0, fd_valid}, 32'd1);
    chk("j2_first", fd_addr, 32'h2000);

    // Jump with rvalid and hold, then a second jump the next cycle.
    lat_min = 2; lat_max = 2;
    do_reset(2);
    repeat (2) @(negedge clk);
    hold_flag_i = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'h2500;
    #1;
    chk("jj_req0", {31'd0, ibus_req_o}, 32'd0);
    @(negedge clk);
    hold_flag_i = 1'b0; jump_addr_i = 32'h3004;
    #1;
    chk("jj_req1", {31'd0, ibus_req_o}, 32'd0);
    chk("jj_addr1", ibus_addr_o, 32'h2500);
    @(negedge clk);
    jump_flag_i = 1'b0;
    #1;
    chk("jj_addr2", ibus_addr_o, 32'h3004);
    chk("jj_nop", inst_o, NOP);
    chk("jj_req2", {31'd0, ibus_req_o}, 32'd1);
    repeat (12) @(negedge clk);
    chk("jj_fd_valid", {31'd0, fd_valid}, 32'd1);
    chk("jj_first", fd_addr, 32'h3004);
    chk("jj_discard", {30'd0, dut.discard_q}, 32'd0);

    // Random stalls, latency, hold and jumps (including a wrap target).
    stall_max = 3; lat_min = 1; lat_max = 4;
    do_reset(2);
    r = deliveries;
    for (int i = 0; i < 1000; i++) begin
      int s;
      s = int'($urandom_range(0, 59));
      hold_flag_i = ($urandom_range(0, 9) < 3);
      jump_flag_i = (s < 2);
      jump_addr_i = (s == 1) ? 32'hFFFF_FFF9 : ($urandom() & 32'h0000_3FFF);
      @(negedge clk);
    end
    hold_flag_i = 1'b0; jump_flag_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("rand_progress", {31'd0, (deliveries - r) > 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
